// File: rtl/div_calc_pkg.sv
// div_calc_pkg: state encodings and display constants shared by the divider controller
package div_calc_pkg;
  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_LOAD_NUM = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD_DEN = 3'd1;
  localparam logic [ST_W-1:0] ST_DIVIDE   = 3'd2;
  localparam logic [ST_W-1:0] ST_SHOW_QUO = 3'd3;
  localparam logic [ST_W-1:0] ST_SHOW_REM = 3'd4;
  localparam logic [ST_W-1:0] ST_ERR      = 3'd5;
  localparam logic [15:0] ERR_LEDS = 16'hFFFF;
endpackage

// File: rtl/div_seq_core.sv
// div_seq_core: restoring divider, one quotient bit per cycle MSB first, done on the WIDTH-th step
module div_seq_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH:0]   r_pr, w_sh, w_pr_n;
  logic [WIDTH-1:0] r_q, w_q_n;
  logic [CW-1:0]    r_cnt;
  logic             r_run, w_ge;
  always_comb begin
    w_sh   = {r_pr[WIDTH-1:0], r_q[WIDTH-1]};
    w_ge   = r_pr[WIDTH] | (w_sh >= {1'b0, divisor});
    w_pr_n = w_ge ? w_sh - {1'b0, divisor} : w_sh;
    w_q_n  = {r_q[WIDTH-2:0], w_ge};
  end
  // results are the values being produced by the current step, valid while done is high
  assign quotient  = w_q_n;
  assign remainder = w_pr_n[WIDTH-1:0];
  assign done      = r_run && (r_cnt == CW'(WIDTH-1));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pr  <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_pr  <= '0;
      r_q   <= dividend;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_pr  <= w_pr_n;
      r_q   <= w_q_n;
      r_cnt <= r_cnt + CW'(1);
      r_run <= !done;
    end
  end
endmodule

// File: rtl/div_calc_ctrl.sv
// div_calc_ctrl: button-driven numerator/denominator entry and sequential division display
// DIVCALC_SAT_EN: when defined, operand editing saturates instead of wrapping
module div_calc_ctrl
  import div_calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_next,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [WIDTH-1:0] leds,
  output logic [ST_W-1:0]  state_o,
  output logic             busy,
  output logic             div_zero
);
  logic [ST_W-1:0]  r_state, w_state_n;
  logic [WIDTH-1:0] r_num, r_den, r_quo, r_rem, r_leds;
  logic [WIDTH-1:0] w_num_n, w_den_n, w_quo_n, w_rem_n, w_leds_n, w_src, w_edit;
  logic [WIDTH-1:0] w_core_q, w_core_r;
  logic             r_busy, r_div_zero, w_up, w_dn, w_start, w_done;
  div_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (w_start),
    .dividend  (r_num),
    .divisor   (r_den),
    .quotient  (w_core_q),
    .remainder (w_core_r),
    .done      (w_done)
  );
  always_comb begin
    w_up  = btn_up & ~btn_down;
    w_dn  = btn_down & ~btn_up;
    w_src = (r_state == ST_LOAD_DEN) ? r_den : r_num;
`ifdef DIVCALC_SAT_EN
    w_edit = (w_up && !(&w_src)) ? w_src + WIDTH'(1) : (w_dn && |w_src) ? w_src - WIDTH'(1) : w_src;
`else
    w_edit = w_up ? w_src + WIDTH'(1) : w_dn ? w_src - WIDTH'(1) : w_src;
`endif
    w_num_n = (r_state == ST_LOAD_NUM && !btn_next) ? w_edit : r_num;
    w_den_n = (r_state == ST_LOAD_DEN && !btn_next) ? w_edit : r_den;
    w_start = (r_state == ST_LOAD_DEN) && btn_next && |r_den;
    w_quo_n = (r_state == ST_DIVIDE && w_done) ? w_core_q : r_quo;
    w_rem_n = (r_state == ST_DIVIDE && w_done) ? w_core_r : r_rem;
    case (r_state)
      ST_LOAD_NUM: w_state_n = btn_next ? ST_LOAD_DEN : ST_LOAD_NUM;
      ST_LOAD_DEN: w_state_n = btn_next ? (|r_den ? ST_DIVIDE : ST_ERR) : ST_LOAD_DEN;
      ST_DIVIDE:   w_state_n = w_done ? ST_SHOW_QUO : ST_DIVIDE;
      ST_SHOW_QUO: w_state_n = btn_next ? ST_SHOW_REM : ST_SHOW_QUO;
      ST_SHOW_REM: w_state_n = btn_next ? ST_LOAD_NUM : ST_SHOW_REM;
      ST_ERR:      w_state_n = btn_next ? ST_LOAD_DEN : ST_ERR;
      default:     w_state_n = ST_LOAD_NUM;
    endcase
    // the display follows the state being entered; DIVIDE keeps showing the denominator
    w_leds_n = (w_state_n == ST_LOAD_NUM) ? w_num_n :
               (w_state_n == ST_LOAD_DEN) ? w_den_n :
               (w_state_n == ST_SHOW_QUO) ? w_quo_n :
               (w_state_n == ST_SHOW_REM) ? w_rem_n :
               (w_state_n == ST_ERR)      ? ERR_LEDS[WIDTH-1:0] : r_leds;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_LOAD_NUM;
      r_num      <= '0;
      r_den      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_leds     <= '0;
      r_busy     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_num      <= w_num_n;
      r_den      <= w_den_n;
      r_quo      <= w_quo_n;
      r_rem      <= w_rem_n;
      r_leds     <= w_leds_n;
      r_busy     <= (w_state_n == ST_DIVIDE);
      r_div_zero <= (w_state_n == ST_ERR);
    end
  end
  assign leds     = r_leds;
  assign state_o  = r_state;
  assign busy     = r_busy;
  assign div_zero = r_div_zero;
endmodule

// File: tb/tb_div_calc_ctrl.sv
// tb_div_calc_ctrl: directed and random checks of div_calc_ctrl at WIDTH=4 and WIDTH=8
module tb_div_calc_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] bn = '0, bu = '0, bd = '0;
  logic [3:0] leds0;
  logic [7:0] leds1;
  logic [2:0] st0, st1;
  logic busy0, busy1, dz0, dz1;
  int n_chk = 0, n_err = 0;
  int m_st[2], m_num[2], m_den[2];
  int wd[2] = '{4, 8};
  bit no_div = 0;

  always #5 clk = ~clk;

  div_calc_ctrl #(.WIDTH(4)) dut0 (
    .clk(clk), .reset(reset), .btn_next(bn[0]), .btn_up(bu[0]), .btn_down(bd[0]),
    .leds(leds0), .state_o(st0), .busy(busy0), .div_zero(dz0));
  div_calc_ctrl #(.WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .btn_next(bn[1]), .btn_up(bu[1]), .btn_down(bd[1]),
    .leds(leds1), .state_o(st1), .busy(busy1), .div_zero(dz1));

  function automatic int o_leds(int d); return d == 0 ? int'(leds0) : int'(leds1); endfunction
  function automatic int o_st(int d);   return d == 0 ? int'(st0) : int'(st1); endfunction
  function automatic int o_busy(int d); return d == 0 ? int'(busy0) : int'(busy1); endfunction
  function automatic int o_dz(int d);   return d == 0 ? int'(dz0) : int'(dz1); endfunction

  function automatic int exp_leds(int d);
    int mx = (1 << wd[d]) - 1;
    case (m_st[d])
      0: return m_num[d];
      1, 2: return m_den[d];
      3: return m_num[d] / m_den[d];
      4: return m_num[d] % m_den[d];
      default: return mx;
    endcase
  endfunction

  function automatic int edit(int d, int v, bit u, bit dn);
    int mx = (1 << wd[d]) - 1;
    if (u == dn) return v;
`ifdef DIVCALC_SAT_EN
    if (u) return v == mx ? v : v + 1;
    return v == 0 ? 0 : v - 1;
`else
    if (u) return (v + 1) & mx;
    return (v - 1) & mx;
`endif
  endfunction

  task automatic check(string tag, int obs, int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(int d, string tag);
    check({tag, " state"}, o_st(d), m_st[d]);
    check({tag, " leds"}, o_leds(d), exp_leds(d));
    check({tag, " busy"}, o_busy(d), int'(m_st[d] == 2));
    check({tag, " div_zero"}, o_dz(d), int'(m_st[d] == 5));
  endtask

  task automatic run_div(int d, string tag);
    int c = 0;
    while (o_busy(d) == 1 && c < 40) begin
      bn[d] = 1'($urandom); bu[d] = 1'($urandom); bd[d] = 1'($urandom);
      @(negedge clk);
      c++;
    end
    bn[d] = 0; bu[d] = 0; bd[d] = 0;
    m_st[d] = 3;
    check({tag, " divide cycles"}, c, wd[d]);
    check_all(d, {tag, " quo"});
  endtask

  task automatic press(int d, bit n, bit u, bit dn, string tag);
    @(negedge clk);
    bn[d] = n; bu[d] = u; bd[d] = dn;
    @(negedge clk);
    bn[d] = 0; bu[d] = 0; bd[d] = 0;
    case (m_st[d])
      0: if (n) m_st[d] = 1; else m_num[d] = edit(d, m_num[d], u, dn);
      1: if (n) m_st[d] = (m_den[d] == 0) ? 5 : 2; else m_den[d] = edit(d, m_den[d], u, dn);
      3: if (n) m_st[d] = 4;
      4: if (n) m_st[d] = 0;
      5: if (n) m_st[d] = 1;
      default: ;
    endcase
    check_all(d, tag);
    if (m_st[d] == 2 && !no_div) run_div(d, tag);
  endtask

  task automatic reps(int d, int k, bit u, bit dn, string tag);
    for (int i = 0; i < k; i++) press(d, 0, u, dn, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 0; m_num[d] = 0; m_den[d] = 0;
      check_all(d, "reset");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    reps(0, 13, 1, 0, "n13");
    press(0, 1, 0, 0, "to_den");
    reps(0, 4, 1, 0, "d4");
    press(0, 1, 0, 0, "go13_4");
    check("13/4 quo", o_leds(0), 3);
    press(0, 1, 0, 0, "show_rem");
    check("13%4 rem", o_leds(0), 1);
    press(0, 1, 0, 0, "back_num");
    check("retained num", o_leds(0), 13);
    do_reset();
    press(0, 0, 0, 1, "down_at0");
    press(0, 0, 1, 0, "up_after");
    reps(0, 16, 1, 0, "up16");
    press(0, 0, 1, 1, "up_down");
    press(0, 1, 1, 0, "next_up");
    press(0, 0, 1, 1, "den_up_down");
    do_reset();
    reps(0, 7, 1, 0, "n7");
    press(0, 1, 0, 0, "to_den0");
    press(0, 1, 0, 0, "to_err");
    check("err leds", o_leds(0), 15);
    check("err state", o_st(0), 5);
    press(0, 0, 1, 0, "err_up_ignored");
    press(0, 1, 0, 0, "err_exit");
    check("err exit state", o_st(0), 1);
    do_reset();
    no_div = 1;
    reps(0, 9, 1, 0, "n9");
    press(0, 1, 0, 0, "to_den9");
    reps(0, 2, 1, 0, "d2");
    press(0, 1, 0, 0, "go9_2");
    @(negedge clk);
    check("2nd divide busy", o_busy(0), 1);
    reset = 0;
    #1;
    check("abort state", o_st(0), 0);
    check("abort leds", o_leds(0), 0);
    check("abort busy", o_busy(0), 0);
    @(negedge clk);
    reset = 1;
    no_div = 0;
    for (int d = 0; d < 2; d++) begin m_st[d] = 0; m_num[d] = 0; m_den[d] = 0; end
    press(0, 0, 1, 0, "post_abort_up");
    press(0, 1, 0, 0, "post_abort_next");
    reps(1, 255, 1, 0, "w8 n255");
    press(1, 1, 0, 0, "w8 to_den");
    reps(1, 16, 1, 0, "w8 d16");
    press(1, 1, 0, 0, "w8 255/16");
    check("w8 255/16 quo", o_leds(1), 15);
    press(1, 1, 0, 0, "w8 rem16");
    check("w8 255%16 rem", o_leds(1), 15);
    press(1, 1, 0, 0, "w8 back");
    press(1, 1, 0, 0, "w8 to_den2");
    reps(1, 15, 0, 1, "w8 d1");
    press(1, 1, 0, 0, "w8 255/1");
    check("w8 255/1 quo", o_leds(1), 255);
    press(1, 1, 0, 0, "w8 rem1");
    check("w8 255%1 rem", o_leds(1), 0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 150; i++)
        press(d, $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), d == 0 ? "rnd4" : "rnd8");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/div_calc_ctrl.md
Name: div_calc_ctrl

Overview:
Parametrised button-driven integer divider controller, the successor to the 4-bit numerator/denominator calculator.
- Takes already debounced, edge-detected button ticks and lets the user load a numerator and a denominator.
- Runs a sequential restoring division, then shows the quotient and the remainder on the LED bus.
- Sits between the debounce/edge-detect front end and the board LEDs.

Parameters:
WIDTH, 4, operand/result width in bits (2..16)

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
btn_next  input  1  single-cycle tick: advance to next state
btn_up  input  1  single-cycle tick: increment the operand being edited
btn_down  input  1  single-cycle tick: decrement the operand being edited
leds  output  WIDTH  displayed value
state_o  output  3  current state encoding
busy  output  1  high while division is running
div_zero  output  1  high in ERR state

Behaviour:
- Reset (reset=0, asynchronous):
  - state=LOAD_NUM.
  - num, den, quo, rem, leds all 0.
  - busy=0, div_zero=0.
  - Release is synchronous to the next clk edge.
- States and encodings: LOAD_NUM=0, LOAD_DEN=1, DIVIDE=2, SHOW_QUO=3, SHOW_REM=4, ERR=5. Unused codes go to LOAD_NUM on the next edge.
- LOAD_NUM:
  - leds=num.
  - btn_up: num+1 modulo 2^WIDTH. btn_down: num-1 modulo 2^WIDTH.
  - btn_up and btn_down in the same cycle: no change.
  - btn_next -> LOAD_DEN. btn_next takes priority over up/down in the same cycle; the operand is unchanged.
- LOAD_DEN: same edit rules applied to den, leds=den. btn_next with den==0 -> ERR; with den!=0 -> DIVIDE.
- DIVIDE:
  - busy=1. leds holds the last displayed value (den).
  - All button ticks are ignored.
  - Restoring algorithm, one quotient bit per cycle, MSB first. Internal partial remainder is WIDTH+1 bits.
  - Exactly WIDTH cycles in DIVIDE; quo/rem are registered on the last of them.
  - Next edge -> SHOW_QUO with busy=0.
  - Latency from the btn_next tick to leds=quotient: WIDTH+1 cycles.
- SHOW_QUO: leds=quo. btn_next -> SHOW_REM.
- SHOW_REM: leds=rem. btn_next -> LOAD_NUM. num and den are retained so the user can edit from the previous values.
- ERR: div_zero=1, leds=all ones. btn_next -> LOAD_DEN with div_zero=0 and den retained (0).
- Outputs are registered: leds/state_o/busy/div_zero change only on clk edges or on reset.
- Reset mid-DIVIDE aborts immediately. All registers return to reset values and no partial result is visible.
- Required result: quo = num / den, rem = num % den, unsigned. Example: num=2^WIDTH-1, den=1 -> quo=2^WIDTH-1, rem=0.

Optional Feature:
DIVCALC_SAT_EN
- Defined: operand editing saturates. btn_down at 0 stays 0; btn_up at 2^WIDTH-1 stays 2^WIDTH-1.
- Undefined: modulo wrap-around as described above.
- No other behaviour changes.

Decomposition:
- Package div_calc_pkg: state encoding constants (3-bit), state width constant, LED pattern for ERR.
- One natural sub-module: div_seq_core (parameter WIDTH).
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, done, with done pulsed for one cycle on the WIDTH-th cycle.
  - The controller owns the FSM and operand counters; the core owns the shift/subtract datapath and its cycle counter.

Test Plan:
- WIDTH=4: reset, 13x btn_up, btn_next, 4x btn_up, btn_next -> busy=1 for exactly 4 cycles, then leds=3 (SHOW_QUO); btn_next -> leds=1 (SHOW_REM); btn_next -> state_o=0, leds=13.
- WIDTH=4, DIVCALC_SAT_EN undefined: btn_down in LOAD_NUM from 0 -> leds=15; btn_up -> leds=0. Same with the macro defined -> leds stays 0, then 15x btn_up then one more btn_up -> leds=15.
- Simultaneous btn_up+btn_down -> operand unchanged. btn_next+btn_up in the same cycle -> state advances, operand unchanged.
- num=7, den=0, btn_next -> state_o=5, div_zero=1, leds=4'b1111; btn_next -> state_o=1, div_zero=0.
- Start 9/2, assert reset=0 on the 2nd DIVIDE cycle -> immediately state_o=0, leds=0, busy=0; after release the buttons operate normally.
- WIDTH=8: num=255, den=16 -> quo=15, rem=15, DIVIDE lasts 8 cycles; num=255, den=1 -> quo=255, rem=0; btn ticks during DIVIDE have no effect.
